// File: rtl/register_file_2r1w.sv
// 32 x 32-bit MIPS-style register file: two combinational read ports, one
// synchronous write port, register 0 hardwired to zero.
module register_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] dw,
    input  logic              rwe,
    output logic [DATA_W-1:0] crs,
    output logic [DATA_W-1:0] crt
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Only registers 1..DEPTH-1 exist as storage; address 0 is a constant.
    logic [DEPTH-1:1]  wr_sel_s;
    logic [DATA_W-1:0] regs_r [1:DEPTH-1];
    logic [DATA_W-1:0] crs_s;
    logic [DATA_W-1:0] crt_s;

    // 32:1 read multiplexer; address 0 falls through to zero.
    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = {DATA_W{1'b0}};
        for (int i = 1; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                val = regs_r[i];
            end
        end
        return val;
    endfunction

    // One-hot write decoder gated by the write enable.
    always_comb begin
        wr_sel_s = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rwe && (rw == ADDR_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Register storage: async clear, per-register write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_sel_s[i]) begin
                    regs_r[i] <= dw;
                end
            end
        end
    end

    // Independent read ports, forced to zero while reset is held.
    always_comb begin
        crs_s = {DATA_W{1'b0}};
        crt_s = {DATA_W{1'b0}};
        if (rst) begin
            crs_s = {DATA_W{1'b0}};
            crt_s = {DATA_W{1'b0}};
        end else begin
            crs_s = read_mux(rs);
            crt_s = read_mux(rt);
        end
    end

    assign crs = crs_s;
    assign crt = crt_s;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w with a queue scoreboard and a
// simple array model of the expected register contents.
module tb_register_file_2r1w;

    logic        clk;
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rw;
    logic [31:0] dw;
    logic        rwe;
    logic [31:0] crs;
    logic [31:0] crt;

    logic [31:0] mdl [0:31];
    logic [31:0] sb [$];
    int          n_checks;
    int          n_fail;

    register_file_2r1w dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rw(rw),
        .dw(dw), .rwe(rwe), .crs(crs), .crt(crt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b,
                             input logic [31:0] ea, input logic [31:0] eb,
                             input string tag);
        rs = a;
        rt = b;
        sb.push_back(ea);
        sb.push_back(eb);
        #1;
        chk($sformatf("%s crs[%0d]", tag, a), crs);
        chk($sformatf("%s crt[%0d]", tag, b), crt);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rwe = 1'b1;
        rw  = a;
        dw  = d;
        tick();
        rwe = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; rs = 5'd0; rt = 5'd0; rw = 5'd0; dw = 32'h0; rwe = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        // Reset held for two edges, sweep both ports
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            read_pair(5'(i), 5'(31 - i), 32'h0, 32'h0, "reset");
        end
        rst = 1'b0;
        #1;
        read_pair(5'd17, 5'd3, 32'h0, 32'h0, "post_reset");

        // $zero write is discarded
        wr(5'd0, 32'h0000_070D);
        read_pair(5'd0, 5'd0, 32'h0, 32'h0, "zero_wr");

        // Basic write/read, unwritten register reads zero
        wr(5'd10, 32'h0000_00AA);
        read_pair(5'd8, 5'd10, 32'h0, 32'h0000_00AA, "wr_rd");

        // Write disabled
        rwe = 1'b0; rw = 5'd10; dw = 32'hFFFF_FFFF;
        tick();
        read_pair(5'd10, 5'd10, mdl[10], mdl[10], "wr_dis");

        // Read-during-write: old value before the edge, new after
        rs = 5'd5; rt = 5'd5; rwe = 1'b1; rw = 5'd5; dw = 32'h1234_5678;
        read_pair(5'd5, 5'd5, mdl[5], mdl[5], "rdw_before");
        tick();
        mdl[5] = 32'h1234_5678;
        read_pair(5'd5, 5'd5, mdl[5], mdl[5], "rdw_after");
        // Holding rwe over another edge rewrites the same value
        tick();
        rwe = 1'b0;
        read_pair(5'd5, 5'd10, mdl[5], mdl[10], "rdw_hold");

        // Distinct pattern in every register, read back on both ports
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), (32'(i) << 24) ^ 32'hA5C3_0F00 ^ ~32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            read_pair(5'(i), 5'((i + 7) % 32), mdl[i], mdl[(i + 7) % 32], "fill");
        end

        // Mid-run reset between edges clears immediately
        wr(5'd31, 32'hDEAD_BEEF);
        read_pair(5'd31, 5'd10, 32'hDEAD_BEEF, mdl[10], "pre_rst");
        #1;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        read_pair(5'd31, 5'd10, 32'h0, 32'h0, "mid_rst");
        rst = 1'b0;
        #1;
        read_pair(5'd31, 5'd10, 32'h0, 32'h0, "mid_rst_rel");
        tick();
        read_pair(5'd31, 5'd1, 32'h0, 32'h0, "after_rst_edge");

        // Write works again after reset
        wr(5'd1, 32'h0BAD_F00D);
        read_pair(5'd1, 5'd31, 32'h0BAD_F00D, 32'h0, "post_rst_wr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
